// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2^2 SDF FFT sequencer.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int MAX_LOG2N = 12;

  function automatic int calc_lat(input int log2n, input int pipe_lat);
    return (1 << log2n) - 1 + pipe_lat;
  endfunction

  // Input is the index counter left-aligned in MAX_LOG2N bits, so stage pair k
  // always sits at bits [MAX_LOG2N-1-2k -: 2]; unused upper pairs are discarded.
  function automatic logic [MAX_LOG2N/2-1:0] rot_decode(input logic [MAX_LOG2N-1:0] c);
    logic [MAX_LOG2N/2-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_LOG2N/2; k++)
      r[k] = c[MAX_LOG2N-2-2*k] & ~c[MAX_LOG2N-1-2*k];
    return r;
  endfunction

endpackage

// File: rtl/fft_ctrl_cnt.sv
// Enable-gated counter: wraps at MAX (SAT=0) or holds at MAX (SAT=1); clr wins.
module fft_ctrl_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en) begin
      if (q != W'(MAX))
        q <= q + 1'b1;
      else if (!SAT)
        q <= '0;
    end
  end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Sequencer for an N=2^LOG2N radix-2^2 SDF FFT: stage selects, -j selects,
// twiddle enable, output framing, input stall and end-of-stream drain.
module fft_sdf_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N      = 4,
  parameter int PIPE_LAT   = 0,
  parameter int MULT_START = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               flush,
  output logic               adv,
  output logic [LOG2N-1:0]   bf_sel,
  output logic [LOG2N/2-1:0] rot_sel,
  output logic               zero_ins,
  output logic               mult_en,
  output logic               out_valid,
  output logic               out_sop,
  output logic [LOG2N-1:0]   out_idx,
  output logic               busy
);

  localparam int N   = 1 << LOG2N;
  localparam int LAT = calc_lat(LOG2N, PIPE_LAT);
  localparam int FW  = $clog2(LAT + 1);

  if (LOG2N % 2 != 0 || LOG2N < 4 || LOG2N > MAX_LOG2N || MULT_START >= LAT) begin : g_param_err
    $error("fft_sdf_ctrl: LOG2N must be even in 4..12 and MULT_START < LAT");
  end

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    drn;
  logic             in_drain;
  logic             drain_done;
  logic             primed;

  assign in_drain   = (state == DRAIN);
  assign drain_done = in_drain && (drn == FW'(LAT - 1));
  assign primed     = (fill == FW'(LAT));

  // Gated by rst so nothing advances while reset is held.
  assign adv = rst & (in_drain | in_valid);

  fft_ctrl_cnt #(.W(LOG2N), .MAX(N - 1), .SAT(1'b0)) u_cnt (
    .clk(clk), .rst(rst), .en(adv), .clr(drain_done), .q(cnt)
  );

  fft_ctrl_cnt #(.W(FW), .MAX(LAT), .SAT(1'b1)) u_fill (
    .clk(clk), .rst(rst), .en(adv), .clr(drain_done), .q(fill)
  );

  fft_ctrl_cnt #(.W(FW), .MAX(LAT), .SAT(1'b1)) u_drn (
    .clk(clk), .rst(rst), .en(adv & in_drain), .clr(drain_done), .q(drn)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      zero_ins <= 1'b0;
      mult_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (flush) begin
          state    <= DRAIN;
          zero_ins <= 1'b1;
        end
        DRAIN: if (drain_done) begin
          state    <= IDLE;
          busy     <= 1'b0;
          zero_ins <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          zero_ins <= 1'b0;
        end
      endcase
      // fill+1 is the advance count reached by this advance
      if (drain_done)
        mult_en <= 1'b0;
      else if (adv && (int'(fill) + 1 >= MULT_START))
        mult_en <= 1'b1;
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_bf
    assign bf_sel[s] = cnt[LOG2N-1-s];
  end

  assign rot_sel = (LOG2N/2)'(rot_decode(MAX_LOG2N'(cnt) << (MAX_LOG2N - LOG2N)));

  // Index is only meaningful with out_valid; held at 0 otherwise so idle/reset read all-zero.
  assign out_valid = adv & primed;
  assign out_idx   = out_valid ? (cnt - LOG2N'(LAT)) : '0;
  assign out_sop   = out_valid & (out_idx == '0);

endmodule
